// File: rtl/am_pkg.sv
// Shared answering-machine definitions: system clock rate, debounce FSM states
// and the default debounce depth used by key_debouncer.
package am_pkg;

   localparam int unsigned SYS_CLK_HZ       = 100_000_000;
   localparam int unsigned DEF_STABLE_TICKS = 20;

   typedef enum logic [1:0] {
      REL    = 2'd0,
      CONF_P = 2'd1,
      PRS    = 2'd2,
      CONF_R = 2'd3
   } deb_state_e;

endpackage : am_pkg

// File: rtl/key_debouncer_if.sv
// Key front-end bundle: divided tick source and raw keys in, clean levels and pulses out.
// KEY_DEBOUNCER_RELEASE_PULSE_EN adds the key_release pulse vector.
interface key_debouncer_if #(
   parameter int unsigned CHANNELS = 4
);
   logic                tick_src;
   logic [CHANNELS-1:0] key_in;
   logic [CHANNELS-1:0] key_level;
   logic [CHANNELS-1:0] key_press;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
   logic [CHANNELS-1:0] key_release;

   modport master (output tick_src, output key_in,
                   input  key_level, input key_press, input key_release);
   modport slave  (input  tick_src, input key_in,
                   output key_level, output key_press, output key_release);
`else
   modport master (output tick_src, output key_in,
                   input  key_level, input key_press);
   modport slave  (input  tick_src, input key_in,
                   output key_level, output key_press);
`endif
endinterface : key_debouncer_if

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, tick-sampled confirm FSM and registered outputs.
// KEY_DEBOUNCER_RELEASE_PULSE_EN adds a one-clk key_release pulse.
module key_debounce_ch
   import am_pkg::*;
#(
   parameter int unsigned STABLE_TICKS   = DEF_STABLE_TICKS,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic key_raw,
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
   output logic key_release,
`endif
   output logic key_level,
   output logic key_press
);

   localparam int unsigned     CNT_W    = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
   // Raw idle level, so the normalised sample resets to "released"
   localparam logic            RAW_IDLE = KEY_ACTIVE_LOW;

   logic             sync1_q, sync1_d, sync2_q, sync2_d;
   logic             sample_c;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_level_q, key_level_d;
   logic             key_press_q, key_press_d;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
   logic             key_release_q, key_release_d;
`endif

   always_comb begin
      sync1_d = key_raw;
      sync2_d = sync1_q;
   end

   assign sample_c = sync2_q ^ KEY_ACTIVE_LOW;

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= RAW_IDLE;
         sync2_q       <= RAW_IDLE;
         state_q       <= REL;
         cnt_q         <= '0;
         key_level_q   <= 1'b0;
         key_press_q   <= 1'b0;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
         key_release_q <= 1'b0;
`endif
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         key_level_q   <= key_level_d;
         key_press_q   <= key_press_d;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
         key_release_q <= key_release_d;
`endif
      end
   end

   // Next state; cnt_q is 0 in REL/PRS, so CNT_LAST == 0 covers STABLE_TICKS == 1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick) begin
         unique case (state_q)
            REL: begin
               if (sample_c) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = PRS;
                     cnt_d   = '0;
                  end else begin
                     state_d = CONF_P;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            CONF_P: begin
               if (!sample_c) begin
                  state_d = REL;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = PRS;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            PRS: begin
               if (!sample_c) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = REL;
                     cnt_d   = '0;
                  end else begin
                     state_d = CONF_R;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            CONF_R: begin
               if (sample_c) begin
                  state_d = PRS;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = REL;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = REL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Level follows the accepted state; pulses mark its edges
   always_comb begin
      key_level_d   = (state_d == PRS) || (state_d == CONF_R);
      key_press_d   = key_level_d & ~key_level_q;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
      key_release_d = ~key_level_d & key_level_q;
`endif
   end

   assign key_level   = key_level_q;
   assign key_press   = key_press_q;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
   assign key_release = key_release_q;
`endif

endmodule : key_debounce_ch

// File: rtl/key_debouncer.sv
// Multichannel key debouncer sampled by the synchronised 1 kHz divider output.
// KEY_DEBOUNCER_RELEASE_PULSE_EN adds per-channel key_release pulses.
module key_debouncer
   import am_pkg::*;
#(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned STABLE_TICKS   = DEF_STABLE_TICKS,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   key_debouncer_if.slave   bus
);

   logic tick_s1_q, tick_s1_d;
   logic tick_s2_q, tick_s2_d;
   logic tick_s3_q, tick_s3_d;
   logic tick_q,    tick_d;

   logic [CHANNELS-1:0] ch_level;
   logic [CHANNELS-1:0] ch_press;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
   logic [CHANNELS-1:0] ch_release;
`endif

   // Tick source is only ever sampled; its rising edge becomes a one-clk strobe
   always_comb begin
      tick_s1_d = bus.tick_src;
      tick_s2_d = tick_s1_q;
      tick_s3_d = tick_s2_q;
      tick_d    = tick_s2_q & ~tick_s3_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_s1_q <= 1'b0;
         tick_s2_q <= 1'b0;
         tick_s3_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         tick_s1_q <= tick_s1_d;
         tick_s2_q <= tick_s2_d;
         tick_s3_q <= tick_s3_d;
         tick_q    <= tick_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      key_debounce_ch #(
         .STABLE_TICKS   (STABLE_TICKS),
         .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick_q),
         .key_raw     (bus.key_in[i]),
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
         .key_release (ch_release[i]),
`endif
         .key_level   (ch_level[i]),
         .key_press   (ch_press[i])
      );
   end

   assign bus.key_level   = ch_level;
   assign bus.key_press   = ch_press;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
   assign bus.key_release = ch_release;
`endif

endmodule : key_debouncer
